// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with pending-write scoreboard and forwarding
module regfile_wb_arbiter #(
  parameter int D    = 32,
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_addr,
  input  logic [D*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [D-1:0]      wr_data,
  input  logic              mark_valid,
  input  logic [4:0]        mark_addr,
  input  logic [4:0]        a1,
  input  logic [4:0]        a2,
  output logic              busy1,
  output logic              busy2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [D-1:0]      fwd_data
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] next_ptr;
  logic          found;
  logic [NREQ-1:0] grant;
  logic [4:0]    sel_addr;
  logic [D-1:0]  sel_data;
  logic [31:0]   busy;
  logic [31:0]   busy_nxt;

  // Rotate the search start to rr_ptr; the first valid requester wins.
  always_comb begin
    int j;
    j        = 0;
    grant    = '0;
    found    = 1'b0;
    gidx     = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        gidx     = PW'(j);
        sel_addr = req_addr[5*j +: 5];
        sel_data = req_data[D*j +: D];
      end
    end
    if (!rst_n) begin
      grant = '0;
      found = 1'b0;
    end
  end

  assign req_ready = grant;
  assign next_ptr  = (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (found) begin
      rr_ptr  <= next_ptr;
      wr_en   <= (sel_addr != 5'd0);
      wr_addr <= sel_addr;
      wr_data <= sel_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Clear first, then set, so a new mark on the committing register survives.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[wr_addr] = 1'b0;
    if (mark_valid && (mark_addr != 5'd0)) busy_nxt[mark_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign fwd1_hit = wr_en && (wr_addr == a1) && (a1 != 5'd0);
  assign fwd2_hit = wr_en && (wr_addr == a2) && (a2 != 5'd0);
  assign busy1    = busy[a1] & ~fwd1_hit;
  assign busy2    = busy[a2] & ~fwd2_hit;
  assign fwd_data = wr_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int D    = 32;
  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_addr;
  logic [D*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [D-1:0]      wr_data;
  logic              mark_valid;
  logic [4:0]        mark_addr;
  logic [4:0]        a1;
  logic [4:0]        a2;
  logic              busy1;
  logic              busy2;
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [D-1:0]      fwd_data;

  regfile_wb_arbiter #(.D(D), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mark_valid(mark_valid), .mark_addr(mark_addr),
    .a1(a1), .a2(a2), .busy1(busy1), .busy2(busy2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [4:0]   addr;
    logic [D-1:0] data;
  } wr_t;

  wr_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int           m_ptr;
  logic [31:0]  m_busy;
  logic         m_wen;
  logic [4:0]   m_waddr;
  logic [D-1:0] m_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] addr, input logic [D-1:0] data);
    req_valid[i]        = v;
    req_addr[5*i +: 5]  = addr;
    req_data[D*i +: D]  = data;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: check combinational outputs mid-cycle, advance the model, check the write stage.
  task automatic tick();
    int           gi;
    logic [NREQ-1:0] g;
    logic         f1, f2;
    logic [31:0]  nb;
    wr_t          e;
    @(negedge clk);
    gi = model_grant();
    g  = '0;
    if (gi >= 0) g[gi] = 1'b1;
    f1 = m_wen && (m_waddr == a1) && (a1 != 0);
    f2 = m_wen && (m_waddr == a2) && (a2 != 0);
    check("req_ready", 64'(req_ready), 64'(g));
    check("fwd1_hit", 64'(fwd1_hit), 64'(f1));
    check("fwd2_hit", 64'(fwd2_hit), 64'(f2));
    check("busy1", 64'(busy1), 64'(m_busy[a1] && !f1));
    check("busy2", 64'(busy2), 64'(m_busy[a2] && !f2));
    if (f1 || f2) check("fwd_data", 64'(fwd_data), 64'(m_wdata));
    @(posedge clk);
    nb = m_busy;
    if (m_wen) nb[m_waddr] = 1'b0;
    if (mark_valid && mark_addr != 0) nb[mark_addr] = 1'b1;
    m_busy = nb;
    if (gi >= 0) begin
      e.en   = (req_addr[5*gi +: 5] != 0);
      e.addr = req_addr[5*gi +: 5];
      e.data = req_data[D*gi +: D];
      q.push_back(e);
      m_ptr   = (gi + 1) % NREQ;
      m_wen   = e.en;
      m_waddr = e.addr;
      m_wdata = e.data;
    end else begin
      m_wen = 1'b0;
    end
    #1;
    if (gi >= 0) begin
      e = q.pop_front();
      check("wr_en", 64'(wr_en), 64'(e.en));
      check("wr_addr", 64'(wr_addr), 64'(e.addr));
      check("wr_data", 64'(wr_data), 64'(e.data));
    end else begin
      check("wr_en_idle", 64'(wr_en), 64'd0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '1;
    req_addr   = '0;
    req_data   = '0;
    mark_valid = 1'b0;
    mark_addr  = '0;
    a1         = 5'd3;
    a2         = 5'd4;
    m_ptr = 0; m_busy = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    req_valid = '0;
    rst_n     = 1'b1;

    // Idle after reset, sweep read addresses
    for (int k = 0; k < 4; k++) begin
      a1 = 5'(k * 7 + 1);
      a2 = 5'(31 - k);
      tick();
    end

    // Full contention: grants rotate 0,1,2,0,1,2
    set_req(0, 1'b1, 5'd5, 32'hA);
    set_req(1, 1'b1, 5'd6, 32'hB);
    set_req(2, 1'b1, 5'd7, 32'hC);
    a1 = 5'd5; a2 = 5'd7;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_order", 64'(m_ptr), 64'((k + 1) % 3));
    end

    // Lone requester 1
    req_valid = '0;
    set_req(1, 1'b1, 5'd9, 32'h1234);
    a1 = 5'd9;
    tick();
    req_valid = '0;
    tick();
    tick();

    // Mark x3, then requester 0 writes x3; observe busy/forward hand-off
    a1 = 5'd3; a2 = 5'd0;
    mark_valid = 1'b1; mark_addr = 5'd3;
    tick();
    mark_valid = 1'b0;
    set_req(0, 1'b1, 5'd3, 32'h55);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("busy1_x3_done", 64'(busy1), 64'd0);

    // R0 write plus R0 mark: grant consumed, no write, pointer advances
    a1 = 5'd0;
    set_req(2, 1'b1, 5'd0, 32'hFFFF);
    mark_valid = 1'b1; mark_addr = 5'd0;
    tick();
    check("r0_ptr", 64'(m_ptr), 64'd0);
    mark_valid = 1'b0;
    set_req(0, 1'b1, 5'd10, 32'h10);
    set_req(1, 1'b1, 5'd11, 32'h11);
    set_req(2, 1'b1, 5'd12, 32'h12);
    tick();
    req_valid = '0;
    tick();

    // Mark x4 at the very edge that commits x4: set wins
    a1 = 5'd4; a2 = 5'd4;
    set_req(1, 1'b1, 5'd4, 32'h44);
    tick();
    req_valid = '0;
    mark_valid = 1'b1; mark_addr = 5'd4;
    tick();
    mark_valid = 1'b0;
    tick();
    check("busy1_x4_set_wins", 64'(busy1), 64'd1);

    // Asynchronous reset in the middle of a burst
    set_req(0, 1'b1, 5'd20, 32'h20);
    set_req(1, 1'b1, 5'd21, 32'h21);
    set_req(2, 1'b1, 5'd22, 32'h22);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", 64'(wr_en), 64'd0);
    check("async_rst_busy1", 64'(busy1), 64'd0);
    check("async_rst_ready", 64'(req_ready), 64'd0);
    a1 = 5'd20;
    #1;
    check("async_rst_busy_x20", 64'(busy1), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (wr, a3, wd) among NREQ writeback requesters, such as the ALU, the load unit and CSR/misc, using round-robin arbitration and a registered write stage. It also holds a per-register pending-write scoreboard and a one-cycle forwarding path, so decode can detect RAW hazards on the two read ports. It sits between the execute/memory writeback sources and the register file.

Parameters:
D, 32, data width; matches register-file word width.
NREQ, 3, number of writeback requesters (2..4).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
req_valid  in  NREQ  requester i has a write pending.
req_addr  in  5*NREQ  destination register of requester i, packed (bits 5i+4:5i).
req_data  in  D*NREQ  write data of requester i, packed (bits Di+D-1:Di).
req_ready  out  NREQ  grant to requester i; combinational, one-hot or zero.
wr_en  out  1  register-file write enable (drives wr).
wr_addr  out  5  register-file write address (drives a3).
wr_data  out  D  register-file write data (drives wd).
mark_valid  in  1  decode issued an instruction that will write mark_addr.
mark_addr  in  5  destination register being marked pending.
a1  in  5  read address 1 (same value as the register-file a1).
a2  in  5  read address 2 (same value as the register-file a2).
busy1  out  1  a1 has an un-committed pending write.
busy2  out  1  a2 has an un-committed pending write.
fwd1_hit  out  1  the current wr stage writes a1; use fwd_data for rs1.
fwd2_hit  out  1  the current wr stage writes a2; use fwd_data for rs2.
fwd_data  out  D  equal to wr_data.

Behaviour:
- Reset (rst_n low, asynchronous): wr_en=0, wr_addr=0, wr_data=0, rr_ptr=0, busy vector all 0. req_ready is 0 while rst_n is low.
- Arbitration (combinational):
  - Search from rr_ptr upward, modulo NREQ. The first i with req_valid[i]=1 gets req_ready[i]=1. All others get 0.
  - A transfer happens when req_valid[i] and req_ready[i] are both 1. At most one transfer per cycle.
  - req_ready never asserts without req_valid. Requesters hold valid, addr and data stable until accepted.
- rr_ptr update: on a transfer by i, rr_ptr <= (i+1) mod NREQ. With no transfer, rr_ptr holds.
- Write stage, latency 1 cycle from accept to wr_en:
  - On a transfer: wr_en <= (addr != 0), wr_addr <= addr, wr_data <= data.
  - With no transfer: wr_en <= 0; wr_addr and wr_data hold.
  - A transfer to R0 is accepted, consumes the grant and advances rr_ptr, but produces no write.
  - The register file commits at the edge that ends the wr_en=1 cycle.
  - There is no downstream backpressure; the write stage always drains.
- Scoreboard (32 busy bits, bit 0 tied 0):
  - Set: at an edge with mark_valid=1 and mark_addr!=0, busy[mark_addr] <= 1.
  - Clear: at an edge with wr_en=1, busy[wr_addr] <= 0.
  - Set and clear on the same register at the same edge: set wins. The new pending write is newer.
  - Set on one register and clear on another at the same edge: both happen.
  - busy1 = busy[a1] & ~fwd1_hit; busy2 = busy[a2] & ~fwd2_hit. Both are combinational.
- Forwarding: fwd1_hit = wr_en & (wr_addr==a1) & (a1!=0); fwd2_hit likewise for a2. fwd_data = wr_data. These cover the cycle in which the register file's asynchronous read still returns the old value.
- Ordering: the block does not reorder writes to the same register from different requesters. Sources own that ordering. Two marks of the same register collapse into one busy bit, which clears on the first write.
- Reset mid-operation: in-flight wr_en drops immediately, the pending grant is lost, and the scoreboard clears. Requesters must also reset.

Test Plan:
- Reset release, all req_valid=0 -> wr_en=0, req_ready=000, busy1=busy2=0 for every a1/a2.
- req_valid=111 held for 6 cycles, addrs 5/6/7, data 0xA/0xB/0xC -> grants in order 0,1,2,0,1,2; wr_en=1 one cycle after each grant with matching addr/data.
- Only requester 1 valid (addr 9, data 0x1234) -> req_ready=010 the same cycle; next cycle wr_en=1, wr_addr=9, wr_data=0x1234; the cycle after, wr_en=0.
- mark x3, then requester 0 writes x3=0x55; a1=3 throughout -> busy1=1 until the wr cycle; in the wr cycle fwd1_hit=1, busy1=0, fwd_data=0x55; afterwards busy1=0 and fwd1_hit=0.
- Write to x0 (data 0xFFFF) together with mark of x0 -> req_ready is granted, wr_en stays 0, busy[0] stays 0, and rr_ptr advances.
- mark x4 at the same edge as the wr_en commit to x4 -> busy[4]=1 after the edge. Then assert rst_n=0 mid-burst -> wr_en=0 and all busy bits cleared immediately, without waiting for a clock edge.
